// File: rtl/step_sequencer_if.sv
// Command/status bundle between a move controller and the step sequencer.
// Latency: none (wires only).
// Backpressure: none; start/stepTick are single-cycle strobes, status is level/pulse.
//
// Signals:
//   stepTick, start, dir, halfStep, stepCount, abort : controller -> sequencer
//   coilOut, busy, done, remaining, position           : sequencer -> controller
interface step_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             stepTick;
    logic             start;
    logic             dir;
    logic             halfStep;
    logic [CNT_W-1:0] stepCount;
    logic             abort;
    logic [3:0]       coilOut;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] position;

    modport master (
        output stepTick, start, dir, halfStep, stepCount, abort,
        input  coilOut, busy, done, remaining, position
    );

    modport slave (
        input  stepTick, start, dir, halfStep, stepCount, abort,
        output coilOut, busy, done, remaining, position
    );
endinterface

// File: rtl/step_sequencer.sv
// Stepper phase sequencer: runs a commanded move of N steps, driving a 4-coil pattern and tracking position.
// Latency: 1 clock from an accepted start or an executed stepTick to updated outputs.
// Backpressure: none; start is dropped outside IDLE and stepTick is dropped outside RUN.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (overrides everything, including mid-move)
//   io   - step_sequencer_if.slave: stepTick/start/dir/halfStep/stepCount/abort in,
//          coilOut/busy/done/remaining/position out
module step_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    step_sequencer_if.slave    io
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ph_q, ph_d;
    logic             dir_q, dir_d;
    logic             half_q, half_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [3:0]       coil_q, coil_d;
    logic [2:0]       ph_inc;

    // Even indices energise one coil, odd indices two adjacent coils,
    // so full-step (+/-2) keeps the drive type of the starting index.
    function automatic logic [3:0] coil_pattern(input logic [2:0] p);
        logic [3:0] c;
        case (p)
            3'd0:    c = 4'b0001;
            3'd1:    c = 4'b0011;
            3'd2:    c = 4'b0010;
            3'd3:    c = 4'b0110;
            3'd4:    c = 4'b0100;
            3'd5:    c = 4'b1100;
            3'd6:    c = 4'b1000;
            default: c = 4'b1001;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= 3'd0;
            dir_q   <= 1'b0;
            half_q  <= 1'b0;
            rem_q   <= '0;
            pos_q   <= '0;
            coil_q  <= 4'b0001;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            coil_q  <= coil_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        dir_d   = dir_q;
        half_d  = half_q;
        rem_d   = rem_q;
        pos_d   = pos_q;
        ph_inc  = half_q ? 3'd1 : 3'd2;

        case (state_q)
            IDLE: begin
                if (io.start) begin
                    if (io.stepCount != '0) begin
                        state_d = RUN;
                        dir_d   = io.dir;
                        half_d  = io.halfStep;
                        rem_d   = io.stepCount;
                    end else begin
                        // Zero-length move still reports completion.
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // Abort wins over a coincident tick: no step, remaining frozen.
                if (io.abort) begin
                    state_d = IDLE;
                end else if (io.stepTick) begin
                    ph_d  = dir_q ? (ph_q + ph_inc) : (ph_q - ph_inc);
                    pos_d = dir_q ? (pos_q + CNT_W'(1)) : (pos_q - CNT_W'(1));
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pattern follows the next index so coilOut changes on the same edge as ph.
        coil_d = coil_pattern(ph_d);
    end

    assign io.coilOut   = coil_q;
    assign io.busy      = (state_q == RUN);
    assign io.done      = (state_q == DONE);
    assign io.remaining = rem_q;
    assign io.position  = pos_q;

endmodule
